// File: rtl/led_scan_controller_pkg.sv
// Shared types and constants for the LED scan controller.
// Optional feature macro: LED_SCAN_BRIGHT_EN (per-slot duty control).
package led_scan_pkg;

  // Scan FSM states. IDLE keeps the display dark; each digit slot is
  // BLANK (all anodes off while char settles) followed by DRIVE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } led_state_e;

  // All anodes off (common-anode, active-low enables).
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Scan order runs from the leftmost digit down to digit 0.
  localparam logic [1:0] DIGIT_FIRST = 2'd3;
  localparam logic [1:0] DIGIT_LAST  = 2'd0;

  // Select one nibble of the 16-bit display value by digit index.
  function automatic logic [3:0] nibble_of(input logic [15:0] value,
                                           input logic [1:0]  idx);
    return value[{idx, 2'b00} +: 4];
  endfunction

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] anode_of(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Number of DRIVE cycles with the anode asserted for a brightness code:
  // ((bright + 1) * drive_len) / 8, so code 7 gives the full drive window.
  function automatic int unsigned bright_on_len(input logic [2:0]  bright,
                                                input int unsigned drive_len);
    return ((32'(bright) + 32'd1) * drive_len) >> 3;
  endfunction

endpackage : led_scan_pkg

// File: rtl/led_scan_controller_if.sv
// Bus between the display datapath / board pins and the scan controller.
// Valid/ready semantics: data_valid is a single-cycle strobe with no
// back-pressure; the controller always accepts the value on the cycle the
// strobe is high and the last strobe before a frame boundary wins.
// Optional feature macro: LED_SCAN_BRIGHT_EN adds the 3-bit `bright` input.
interface led_scan_controller_if;
  import led_scan_pkg::*;

  // Datapath side
  logic        enable;
  logic [15:0] data;
  logic        data_valid;
`ifdef LED_SCAN_BRIGHT_EN
  logic [2:0]  bright;
`endif

  // Display side
  logic [3:0]  char;
  logic [3:0]  an;
  logic [1:0]  digit_sel;
  logic        frame_done;

  // Debug visibility of the scan FSM and slot counter
  led_state_e  state_dbg;
  logic [15:0] slot_cnt_dbg;

  // Producer of display values and consumer of the pin outputs.
  modport master (
`ifdef LED_SCAN_BRIGHT_EN
    output bright,
`endif
    output enable, data, data_valid,
    input  char, an, digit_sel, frame_done, state_dbg, slot_cnt_dbg
  );

  // The scan controller itself.
  modport slave (
`ifdef LED_SCAN_BRIGHT_EN
    input  bright,
`endif
    input  enable, data, data_valid,
    output char, an, digit_sel, frame_done, state_dbg, slot_cnt_dbg
  );

endinterface : led_scan_controller_if

// File: rtl/led_scan_controller_timer.sv
// Slot counter for the LED scan controller. Counts cycles inside the current
// phase (BLANK or DRIVE) and flags the last cycle of each phase. The parent
// clears it on every state change, so it never free-runs.
module led_scan_timer #(
  parameter int REFRESH_DIV = 20000,
  parameter int DEAD_CYCLES = 8,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             blank_end,
  output logic             slot_end
);

  // Highest value the counter may ever hold.
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(REFRESH_DIV - 1);
  // Last cycle of the blanking phase.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DEAD_CYCLES - 1);
  // Last cycle of the drive phase (counter restarts at DRIVE entry).
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - DEAD_CYCLES - 1);

  // Phase cycle counter; the CNT_MAX guard keeps it bounded even if the
  // parent were ever to miss a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_MAX)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // End-of-phase strobes, qualified by the FSM state in the parent.
  always_comb begin
    blank_end = (cnt == BLANK_LAST);
    slot_end  = (cnt == DRIVE_LAST);
  end

endmodule : led_scan_timer

// File: rtl/led_scan_controller.sv
// LED scan controller: time-multiplexes one hex-to-7-segment decoder across
// four common-anode digits, scanning 3,2,1,0 with a blanking dead-time
// before each digit. New display values are double-buffered and only take
// effect at a frame boundary so a frame never tears.
// Optional feature macro: LED_SCAN_BRIGHT_EN (duty control via `bright`).
// REFRESH_DIV must exceed DEAD_CYCLES + 1 and DEAD_CYCLES must be >= 1.
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 20000,
  parameter int DEAD_CYCLES = 8
) (
  input logic                  clk,
  input logic                  reset,
  led_scan_controller_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
`ifdef LED_SCAN_BRIGHT_EN
  localparam int unsigned DRIVE_LEN = REFRESH_DIV - DEAD_CYCLES;
`endif

  led_state_e       state;
  led_state_e       state_next;

  logic [CNT_W-1:0] slot_cnt;
  logic             blank_end;
  logic             slot_end;
  logic             cnt_clear;

  logic [15:0]      active_q;
  logic [15:0]      active_next;
  logic [15:0]      pending_q;
  logic             pending_flag;

  logic [1:0]       digit_q;
  logic [1:0]       digit_next;
  logic [3:0]       char_q;

  logic             blank_entry;
  logic             frame_entry;
  logic             drive_on;

  logic [3:0]       an_d;
  logic             frame_done_d;

`ifdef LED_SCAN_BRIGHT_EN
  logic [2:0]       bright_q;
`endif

  led_scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .cnt       (slot_cnt),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the slot/frame boundary decodes derived from it.
  always_comb begin
    state_next = state;
    if (!bus.enable) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_next = BLANK;
        BLANK:   if (blank_end) state_next = DRIVE;
        DRIVE:   if (slot_end)  state_next = BLANK;
        default: state_next = IDLE;
      endcase
    end

    // A new slot starts whenever BLANK is entered from IDLE or DRIVE.
    blank_entry = (state_next == BLANK) && (state != BLANK);
    // From IDLE the scan always restarts at the leftmost digit; 0 wraps to 3.
    digit_next  = (state == DRIVE) ? (digit_q - 2'd1) : DIGIT_FIRST;
    frame_entry = blank_entry && (digit_next == DIGIT_FIRST);

    // At a frame boundary a coincident strobe bypasses the pending buffer.
    active_next = active_q;
    if (frame_entry) begin
      if (bus.data_valid) begin
        active_next = bus.data;
      end else if (pending_flag) begin
        active_next = pending_q;
      end
    end

    // Counter restarts on every phase change and is held at zero in IDLE.
    cnt_clear = (state_next != state) || (state == IDLE);
  end

  // Display buffers and per-slot registers (digit, nibble, brightness).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q     <= 16'h0000;
      pending_q    <= 16'h0000;
      pending_flag <= 1'b0;
      digit_q      <= DIGIT_FIRST;
      char_q       <= 4'h0;
`ifdef LED_SCAN_BRIGHT_EN
      bright_q     <= 3'd7;
`endif
    end else begin
      active_q <= active_next;

      if (frame_entry) begin
        pending_flag <= 1'b0;
      end else if (bus.data_valid) begin
        pending_q    <= bus.data;
        pending_flag <= 1'b1;
      end

      if (blank_entry) begin
        digit_q  <= digit_next;
        char_q   <= nibble_of(active_next, digit_next);
`ifdef LED_SCAN_BRIGHT_EN
        bright_q <= bus.bright;
`endif
      end else if (state_next == IDLE) begin
        digit_q <= DIGIT_FIRST;
      end
    end
  end

  // Anode duty window inside DRIVE; full window unless brightness is enabled.
`ifdef LED_SCAN_BRIGHT_EN
  assign drive_on = (32'(slot_cnt) < bright_on_len(bright_q, DRIVE_LEN));
`else
  assign drive_on = 1'b1;
`endif

  // Output decode: anodes only in DRIVE, frame pulse on the final cycle of
  // digit 0 when the frame actually completes.
  always_comb begin
    an_d         = AN_OFF;
    frame_done_d = 1'b0;
    if (state == DRIVE) begin
      if (drive_on) begin
        an_d = anode_of(digit_q);
      end
      if (slot_end && bus.enable && (digit_q == DIGIT_LAST)) begin
        frame_done_d = 1'b1;
      end
    end
  end

  assign bus.char         = char_q;
  assign bus.an           = an_d;
  assign bus.digit_sel    = digit_q;
  assign bus.frame_done   = frame_done_d;
  assign bus.state_dbg    = state;
  assign bus.slot_cnt_dbg = 16'(slot_cnt);

endmodule : led_scan_controller

// File: tb/tb_led_scan_controller.sv
// Testbench for led_scan_controller with REFRESH_DIV=16, DEAD_CYCLES=2.
// Optional feature macro: LED_SCAN_BRIGHT_EN (exercises bright=3).
module tb_led_scan_controller;
  import led_scan_pkg::*;

  localparam int RD = 16;
  localparam int DC = 2;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   t_fd = 0;

  // Expected slot queue: {gap(8), char(4), an(4), drive_len(8)}; gap 0 = unchecked
  logic [23:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        cur_open = 1'b0;
  logic [23:0] cur_exp = '0;
  logic [3:0]  prev_an = 4'hF;
  int          off_run = 0;
  int          drv_run = 0;

  led_scan_controller_if bus();

  led_scan_controller #(
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_slot(input int gap, input logic [3:0] ch, input logic [3:0] an, input int len);
    exp_q.push_back({8'(gap), ch, an, 8'(len)});
  endtask

  task automatic push_frame(input logic [3:0] c3, input logic [3:0] c2, input logic [3:0] c1,
                            input logic [3:0] c0, input int gap_first, input int gap_rest,
                            input int len);
    push_slot(gap_first, c3, 4'b0111, len);
    push_slot(gap_rest,  c2, 4'b1011, len);
    push_slot(gap_rest,  c1, 4'b1101, len);
    push_slot(gap_rest,  c0, 4'b1110, len);
  endtask

  task automatic strobe(input logic [15:0] v);
    bus.data       = v;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.data       = 16'h0000;
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout, got no event, expected one within budget", name);
  endtask

  task automatic wait_an(input logic [3:0] pat, input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.an == pat) return;
    end
    timeout(name);
  endtask

  task automatic wait_fd(input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.frame_done) return;
    end
    timeout(name);
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !cur_open) return;
    end
    timeout(name);
  endtask

  // Monitor: a slot is presented when the anodes go active; pop and compare
  // at drive start, then check the drive length when the anodes go dark.
  always @(posedge clk) begin
    #1;
    if (bus.an == 4'hF) begin
      if (prev_an != 4'hF && mon_en && cur_open) begin
        check("slot_len", 32'(drv_run), 32'(cur_exp[7:0]));
        cur_open = 1'b0;
      end
      off_run++;
    end else begin
      if (prev_an == 4'hF) begin
        drv_run = 0;
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL slot_unexpected: got an=%b char=%h, expected no slot", bus.an, bus.char);
          end else begin
            cur_exp = exp_q.pop_front();
            check("slot_char", 32'(bus.char), 32'(cur_exp[15:12]));
            check("slot_an", 32'(bus.an), 32'(cur_exp[11:8]));
            if (cur_exp[23:16] != 8'd0) check("slot_gap", 32'(off_run), 32'(cur_exp[23:16]));
            cur_open = 1'b1;
          end
        end
      end
      drv_run++;
      off_run = 0;
    end
    if (!mon_en) cur_open = 1'b0;
    prev_an = bus.an;
  end

  // Stimulus
  initial begin
    reset          = 1'b0;
    bus.enable     = 1'b0;
    bus.data       = 16'h0000;
    bus.data_valid = 1'b0;
`ifdef LED_SCAN_BRIGHT_EN
    bus.bright     = 3'd7;
`endif
    repeat (3) @(negedge clk);
    check("rst_an", 32'(bus.an), 32'h0000000F);
    check("rst_char", 32'(bus.char), 32'h0);
    check("rst_digit", 32'(bus.digit_sel), 32'd3);
    check("rst_fd", 32'(bus.frame_done), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(IDLE));

    reset = 1'b1;
    @(negedge clk);
    check("idle_an", 32'(bus.an), 32'h0000000F);

    // Load 1234 while idle, then start scanning
    strobe(16'h1234);
    push_frame(4'h1, 4'h2, 4'h3, 4'h4, 0, DC, RD - DC);
    mon_en     = 1'b1;
    bus.enable = 1'b1;

    // Mid-frame update shows only from the next frame
    wait_an(4'b1011, "wait_f1_d2");
    strobe(16'hABCD);
    push_frame(4'hA, 4'hB, 4'hC, 4'hD, DC, DC, RD - DC);
    wait_fd("fd1");
    t_fd = cyc;
    wait_fd("fd2");
    check("frame_period", 32'(cyc - t_fd), 32'd64);
    check("fd_an", 32'(bus.an), 32'b1110);
    check("fd_digit", 32'(bus.digit_sel), 32'd0);
    t_fd = cyc;

    // Strobe on the exact frame-boundary cycle loads straight to active
    push_frame(4'h0, 4'h0, 4'hF, 4'hF, DC, DC, RD - DC);
    strobe(16'h00FF);

    // Two strobes in one frame: last one wins
    wait_an(4'b1011, "wait_f3_d2");
    strobe(16'h1111);
    wait_an(4'b1110, "wait_f3_d0");
    strobe(16'h5678);
    push_frame(4'h5, 4'h6, 4'h7, 4'h8, DC, DC, RD - DC);
    wait_fd("fd3");
    check("frame_period2", 32'(cyc - t_fd), 32'd64);

    // Next frame repeats 5678; it is cut short during digit 1
    push_slot(DC, 4'h5, 4'b0111, RD - DC);
    push_slot(DC, 4'h6, 4'b1011, RD - DC);
    push_slot(DC, 4'h7, 4'b1101, RD - DC);
    wait_fd("fd4");
    wait_an(4'b1101, "wait_f5_d1");
    mon_en     = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    check("dis_an", 32'(bus.an), 32'h0000000F);
    check("dis_digit", 32'(bus.digit_sel), 32'd3);
    check("dis_state", 32'(bus.state_dbg), 32'(IDLE));

    // Reload while dark, re-enable restarts at digit 3 blanking
    strobe(16'h9ABC);
    bus.enable = 1'b1;
    @(negedge clk);
    check("reen_state", 32'(bus.state_dbg), 32'(BLANK));
    check("reen_char", 32'(bus.char), 32'h9);
    check("reen_digit", 32'(bus.digit_sel), 32'd3);
    check("reen_an", 32'(bus.an), 32'h0000000F);
    push_frame(4'h9, 4'hA, 4'hB, 4'hC, 0, DC, RD - DC);
    mon_en = 1'b1;
    wait_fd("fd_9abc");
    wait_drain("drain_9abc");
    mon_en = 1'b0;

    // Asynchronous reset in the middle of a drive
    wait_an(4'b1011, "wait_rst_d2");
    #1 reset = 1'b0;
    #1;
    check("arst_an", 32'(bus.an), 32'h0000000F);
    check("arst_char", 32'(bus.char), 32'h0);
    check("arst_digit", 32'(bus.digit_sel), 32'd3);
    check("arst_fd", 32'(bus.frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, 0, DC, RD - DC);
    mon_en = 1'b1;
    wait_fd("fd_zero");

`ifdef LED_SCAN_BRIGHT_EN
    // bright=3: 7 of 14 drive cycles lit, then 7 dark plus 2 blank
    bus.bright = 3'd3;
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, DC, 9, 7);
`else
    push_frame(4'h0, 4'h0, 4'h0, 4'h0, DC, DC, RD - DC);
`endif
    wait_drain("drain_last");
    mon_en = 1'b0;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_led_scan_controller

// File: doc/led_scan_controller.md
Name: led_scan_controller

Overview:
- Time-multiplexes one hex-to-7-segment decoder across four common-anode digits.
- Sequences digit selection, presents the selected nibble on `char` and drives active-low anodes.
- Inserts a blanking dead-time between digits to prevent ghosting.
- Sits between the datapath producing a 16-bit display value and the LED decoder / board pins.

Parameters:
- REFRESH_DIV, 20000: clock cycles per digit slot, blanking included; must be > DEAD_CYCLES + 1.
- DEAD_CYCLES, 8: cycles per slot with all anodes off while `char` settles; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scanning; 0 = display dark.
- data  input  16  display value; data[15:12] is the leftmost digit (digit 3), data[3:0] is digit 0.
- data_valid  input  1  single-cycle load strobe for `data`.
- char  output  4  nibble to LED decoder input.
- an  output  4  active-low anode enables, one-hot-low while driving.
- digit_sel  output  2  index of the digit currently on `char`.
- frame_done  output  1  one-cycle pulse at end of digit 0 drive.

Behaviour:
- Reset (reset=0, asynchronous) drives:
  - an=4'b1111, char=4'h0, digit_sel=2'd3, frame_done=0;
  - active register=16'h0000, pending register=16'h0000, pending flag=0;
  - state=IDLE, slot counter=0.
- Load path:
  - data_valid=1 captures `data` into pending and sets the pending flag.
  - Pending is copied to active only at a frame boundary (entry to BLANK of digit 3), then the flag clears. No tearing within a frame.
  - data_valid coinciding with a frame boundary writes `data` straight to active.
  - Multiple strobes within one frame: the last one wins.
- States:
  - IDLE: an=1111. Go to BLANK(digit 3) the cycle after enable=1.
  - BLANK: an=1111; char=active nibble[digit_sel]; lasts DEAD_CYCLES cycles, then DRIVE.
  - DRIVE: an[digit_sel]=0, others 1; lasts REFRESH_DIV-DEAD_CYCLES cycles, then BLANK of the next digit.
- Digit order is 3,2,1,0 and wraps back to 3.
- char and digit_sel update on BLANK entry; they are stable for the whole slot.
- frame_done=1 for exactly the last cycle of DRIVE(digit 0).
- enable=0 in any state: the next clock goes to IDLE, an=1111, digit_sel=3, counter cleared. A later enable restarts at digit 3 BLANK.
- Asynchronous reset mid-frame forces the reset values immediately. No partial frame completes.
- Slot counter width is clog2(REFRESH_DIV). It wraps only via state transitions and never free-runs past REFRESH_DIV-1.

Optional Feature:
- Macro: LED_SCAN_BRIGHT_EN.
- With the macro defined:
  - Adds input port `bright`, 3 bits.
  - In DRIVE, the anode is asserted only for the first ((bright+1)*(REFRESH_DIV-DEAD_CYCLES))/8 cycles, then an=1111 for the rest of the slot.
  - `bright` is sampled at BLANK entry.
  - bright=7 is identical to the non-macro build.
- Without the macro: no `bright` port; full duty for the whole DRIVE.

Decomposition:
- Shared package led_scan_pkg holds:
  - state enum {IDLE, BLANK, DRIVE};
  - AN_OFF=4'b1111;
  - DIGIT_FIRST=2'd3, DIGIT_LAST=2'd0.
- Natural sub-module: led_scan_timer, the slot counter. It emits blank_end and slot_end strobes from DEAD_CYCLES/REFRESH_DIV and clears on state change.
- The LED decoder is instantiated by the parent, not inside this block.

Test Plan:
- REFRESH_DIV=16, DEAD_CYCLES=2, reset released, enable=1, data=16'h1234 loaded → slots drive:
  - digit 3: char=1, an=0111;
  - digit 2: char=2, an=1011;
  - digit 1: char=3, an=1101;
  - digit 0: char=4, an=1110.
  - Each slot has 2 cycles of an=1111 then 14 driving; frame_done pulses every 64 cycles.
- data_valid with 16'hABCD during the digit 2 drive → rest of the frame still shows 3,4; the next frame shows A,B,C,D.
- data_valid on the exact frame-boundary cycle with 16'h00FF → that frame shows 0,0,F,F.
- enable dropped during DRIVE(digit 1) → next cycle an=1111, digit_sel=3. Re-enable → BLANK of digit 3, char=data[15:12].
- reset asserted mid-DRIVE → an=1111 and char=0 asynchronously, before the next clock edge. After release, active=0 and digit 3 shows 0.
- LED_SCAN_BRIGHT_EN, bright=3 (REFRESH_DIV=16, DEAD_CYCLES=2) → 7 of 14 drive cycles have the anode low, the remaining 7 have an=1111.
